popcount_pattern_gen: RTL and testbench

Sequential generator that works the inverse of the 8-bit Hamming-weight (popcount) unit. Given a requested weight k, it emits, in ascending numeric order, every 8-bit word whose popcount equals k over a valid/ready stream, and marks the final word. It sits beside the popcount datapath as a stimulus/enumeration source for weight-based test and self-check logic.

---
 rtl/popcount_pattern_gen_if.sv | 24 ++
 rtl/popcount_pattern_gen.sv | 142 ++++++++++++++
 tb/tb_popcount_pattern_gen.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/popcount_pattern_gen_if.sv
// Stream and control bundle for the weight-k pattern generator.
// The generator connects through the slave modport; the driving side uses master.
interface popcount_pattern_gen_if;
    logic       start;
    logic [3:0] weight;
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       done;
    logic       err;
    logic [6:0] count;

    modport master (
        output start, weight, out_ready,
        input  busy, out_valid, out_data, out_last, done, err, count
    );

    modport slave (
        input  start, weight, out_ready,
        output busy, out_valid, out_data, out_last, done, err, count
    );
endinterface

// File: rtl/popcount_pattern_gen.sv
// Enumerates every 8-bit word of popcount k in ascending order over a
// valid/ready stream, flagging the final word and counting accepted words.
module popcount_pattern_gen (
    input  logic                 clk,
    input  logic                 rst_n,
    popcount_pattern_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_e;

    state_e     state_q, state_d;
    logic [3:0] k_q, k_d;
    logic [7:0] cand_q, cand_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_last_q, out_last_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [6:0] count_q, count_d;

    logic [3:0] cand_weight;
    logic [8:0] ones_mask;
    logic [8:0] last_shifted;
    logic [7:0] last_word;
    logic       match;
    logic       is_last;
    logic       slot_free;
    logic       handshake;
    logic       start_ok;

    always_comb begin
        cand_weight = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            cand_weight = cand_weight + {3'b000, cand_q[i]};
        end
    end

    // Highest word of weight k: k ones packed at the top of the byte.
    always_comb begin
        ones_mask    = (9'd1 << k_q) - 9'd1;
        last_shifted = ones_mask << (4'd8 - k_q);
        last_word    = last_shifted[7:0];
    end

    assign match     = (cand_weight == k_q);
    assign is_last   = (cand_q == last_word);
    assign slot_free = !out_valid_q || bus.out_ready;
    assign handshake = out_valid_q && bus.out_ready;
    assign start_ok  = bus.start && (bus.weight <= 4'd8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok) state_d = SCAN;
            SCAN:    if (match && slot_free && is_last) state_d = DRAIN;
            DRAIN:   if (handshake) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        k_d         = k_q;
        cand_d      = cand_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        count_d     = handshake ? count_q + 7'd1 : count_q;

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    k_d     = bus.weight;
                    cand_d  = '0;
                    count_d = '0;
                end else if (bus.start) begin
                    err_d = 1'b1;
                end
            end
            SCAN: begin
                if (match) begin
                    // A matching candidate waits here until the output slot frees up.
                    if (slot_free) begin
                        out_data_d  = cand_q;
                        out_valid_d = 1'b1;
                        out_last_d  = is_last;
                        if (!is_last) cand_d = cand_q + 8'd1;
                    end
                end else begin
                    cand_d = cand_q + 8'd1;
                    if (slot_free) out_valid_d = 1'b0;
                end
            end
            DRAIN: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q         <= '0;
            cand_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            k_q         <= k_d;
            cand_q      <= cand_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            err_q       <= err_d;
            count_q     <= count_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_popcount_pattern_gen.sv
// Bench for popcount_pattern_gen: table of weight runs checked against a
// scoreboard of expected words, plus error, busy-start and mid-run reset cases.
module tb_popcount_pattern_gen;
    logic clk = 1'b0;
    logic rst_n;

    popcount_pattern_gen_if bus ();

    popcount_pattern_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        int w;
        int mode;
        int cnt;
        int first;
        int last;
        int poke;
    } vec_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   rdy_mode = 0;
    int   words_seen;
    int   done_cnt;
    int   first_data;
    int   last_data;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rdy_mode != 0) bus.out_ready = 1'($urandom_range(0, 1));
        else               bus.out_ready = 1'b1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.done) done_cnt++;
            if (prev_stall) begin
                chk("valid_held", int'(bus.out_valid), 1);
                chk("data_stable", int'(bus.out_data), int'(prev_data));
                chk("last_stable", int'(bus.out_last), int'(prev_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", int'(bus.out_data), -1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("word_data", int'(bus.out_data), int'(e.data));
                    chk("word_last", int'(bus.out_last), int'(e.last));
                end
                if (words_seen == 0) first_data = int'(bus.out_data);
                last_data = int'(bus.out_data);
                words_seen++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end
    end

    task automatic push_expected(input int w);
        for (int i = 0; i < 256; i++) begin
            if ($countones(8'(i)) == w) q.push_back('{data: 8'(i), last: 1'b0});
        end
        if (q.size() > 0) q[q.size() - 1].last = 1'b1;
    endtask

    task automatic run_case(input vec_t v);
        int cyc;
        bit got;
        q.delete();
        push_expected(v.w);
        rdy_mode   = v.mode;
        words_seen = 0;
        done_cnt   = 0;
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.weight = 4'(v.w);
        @(posedge clk); #1;
        bus.start  = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.out_valid && cyc < 400);
        chk($sformatf("latency_k%0d", v.w), cyc, v.first + 2);
        got = 1'b0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            if (v.poke != 0 && c == v.poke) begin
                bus.start  = 1'b1;
                bus.weight = 4'd5;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) got = 1'b1;
        end
        bus.start = 1'b0;
        chk($sformatf("done_seen_k%0d", v.w), int'(got), 1);
        chk($sformatf("busy_at_done_k%0d", v.w), int'(bus.busy), 0);
        chk($sformatf("count_k%0d", v.w), int'(bus.count), v.cnt);
        chk($sformatf("words_k%0d", v.w), words_seen, v.cnt);
        chk($sformatf("first_k%0d", v.w), first_data, v.first);
        chk($sformatf("last_k%0d", v.w), last_data, v.last);
        chk($sformatf("queue_empty_k%0d", v.w), q.size(), 0);
        @(negedge clk);
        @(negedge clk);
        chk($sformatf("done_once_k%0d", v.w), done_cnt, 1);
        chk($sformatf("valid_idle_k%0d", v.w), int'(bus.out_valid), 0);
        chk($sformatf("count_hold_k%0d", v.w), int'(bus.count), v.cnt);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"},  int'(bus.busy), 0);
        chk({tag, "_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_data"},  int'(bus.out_data), 0);
        chk({tag, "_last"},  int'(bus.out_last), 0);
        chk({tag, "_done"},  int'(bus.done), 0);
        chk({tag, "_err"},   int'(bus.err), 0);
        chk({tag, "_count"}, int'(bus.count), 0);
    endtask

    vec_t tbl[6];
    int   bad_w[2];

    initial begin
        tbl[0] = '{w: 0, mode: 0, cnt: 1,  first: 'h00, last: 'h00, poke: 0};
        tbl[1] = '{w: 1, mode: 0, cnt: 8,  first: 'h01, last: 'h80, poke: 0};
        tbl[2] = '{w: 4, mode: 1, cnt: 70, first: 'h0F, last: 'hF0, poke: 0};
        tbl[3] = '{w: 8, mode: 0, cnt: 1,  first: 'hFF, last: 'hFF, poke: 0};
        tbl[4] = '{w: 3, mode: 1, cnt: 56, first: 'h07, last: 'hE0, poke: 0};
        tbl[5] = '{w: 2, mode: 0, cnt: 28, first: 'h03, last: 'hC0, poke: 10};
        bad_w[0] = 9;
        bad_w[1] = 15;

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.weight    = 4'd0;
        bus.out_ready = 1'b1;
        prev_stall    = 1'b0;
        words_seen    = 0;
        done_cnt      = 0;
        first_data    = 0;
        last_data     = 0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (tbl[i]) run_case(tbl[i]);

        foreach (bad_w[i]) begin
            @(posedge clk); #1;
            bus.start  = 1'b1;
            bus.weight = 4'(bad_w[i]);
            @(posedge clk); #1;
            bus.start  = 1'b0;
            @(negedge clk);
            chk($sformatf("err_pulse_w%0d", bad_w[i]), int'(bus.err), 1);
            chk($sformatf("err_busy_w%0d", bad_w[i]), int'(bus.busy), 0);
            chk($sformatf("err_valid_w%0d", bad_w[i]), int'(bus.out_valid), 0);
            @(negedge clk);
            chk($sformatf("err_clear_w%0d", bad_w[i]), int'(bus.err), 0);
            chk($sformatf("err_idle_w%0d", bad_w[i]), int'(bus.busy), 0);
        end

        begin
            int cyc;
            q.delete();
            push_expected(2);
            rdy_mode   = 0;
            words_seen = 0;
            @(posedge clk); #1;
            bus.start  = 1'b1;
            bus.weight = 4'd2;
            @(posedge clk); #1;
            bus.start  = 1'b0;
            cyc = 0;
            while (words_seen < 3 && cyc < 400) begin
                @(negedge clk);
                cyc++;
            end
            chk("midrun_words_reached", int'(words_seen >= 3), 1);
            #1;
            rst_n = 1'b0;
            #1;
            check_reset_values("midrun_reset");
            q.delete();
            @(posedge clk); #1;
            rst_n = 1'b1;
            run_case('{w: 7, mode: 0, cnt: 8, first: 'h7F, last: 'hFE, poke: 0});
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
